step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
Consumes the single-cycle Step tick from the tempo counter and advances a looping step index over a NUM_STEPS x NUM_TRACKS on/off pattern. On each step it emits per-track one-cycle triggers and fixed-length gates for the drum/tone voice stages downstream. It also owns pattern storage and a cell-toggle edit port driven by the UI/switch decoder.

Parameters:
NUM_STEPS, 16, steps per loop; power of two, 2..64.
NUM_TRACKS, 4, independent voice tracks, 1..8.
GATE_CYCLES, 2_500_000, gate high time in Clock cycles (50 ms at 50 MHz); must be at least 1.
STEP_W, $clog2(NUM_STEPS), width of step index (derived, not overridden).
TRK_W, max(1,$clog2(NUM_TRACKS)), width of track select (derived).

Ports:
Clock  in  1  system clock, 50 MHz.
nReset  in  1  synchronous, active-low reset.
Step  in  1  one-cycle tempo tick from the tempo counter.
Play  in  1  one-cycle pulse: start or restart playback from step 0.
Stop  in  1  one-cycle pulse: halt playback.
EditToggle  in  1  one-cycle pulse: invert pattern cell [EditTrack][EditStep].
EditTrack  in  TRK_W  track of the edit cursor.
EditStep  in  STEP_W  step of the edit cursor.
Clear  in  1  one-cycle pulse: zero the whole pattern.
StepIndex  out  STEP_W  step currently sounding.
Trig  out  NUM_TRACKS  one-cycle trigger per track.
Gate  out  NUM_TRACKS  per-track gate, high GATE_CYCLES cycles.
Playing  out  1  high in ARMED or PLAYING.
EditValue  out  1  registered pattern bit at the edit cursor.

Behaviour:
- Reset (nReset=0 at a Clock edge): state IDLE; StepIndex, Trig, Gate, Playing and EditValue all 0; pattern cleared to all 0; gate counter 0.
- FSM states IDLE, ARMED, PLAYING. Priority on any cycle: Stop > Play > Step.
- IDLE: Play -> ARMED with StepIndex=0. Step is ignored.
- ARMED: Step -> PLAYING. Sound step 0; StepIndex is not incremented. The tempo counter emits a tick on start, so step 0 sounds on the first tick.
- PLAYING: Step -> StepIndex = StepIndex+1, wrapping NUM_STEPS-1 -> 0. Sound the new index.
- Play in ARMED or PLAYING: restart. Go to ARMED, StepIndex=0, Gate cleared, Trig 0.
- Stop in any state: go to IDLE next cycle. StepIndex=0, Trig=0, Gate=0.
- Sounding step s: Trig <= pattern column s, registered, so 1 cycle after the Step edge. Gate mask loads with the same column. Gate counter reloads to GATE_CYCLES.
- Gate counter decrements each cycle while nonzero. When it reaches 0, Gate goes to 0. Gate[t] is therefore high for exactly GATE_CYCLES cycles starting with the Trig cycle.
- Next step before the gate expires: counter reloads and mask is replaced. A track set in both steps keeps Gate high continuously; the retrigger is visible on Trig only.
- Pattern read for Trig uses the pre-edit value. A toggle of the sounding cell in the same cycle as Step takes effect on the next loop.
- Clear and EditToggle in the same cycle: Clear wins and the toggle is dropped.
- Edits and Clear are accepted in every state.
- EditValue is registered and reflects the post-edit cell 1 cycle after the edit. Cursor changes show 1 cycle later.
- Step pulses held high more than 1 cycle are treated as one tick per high cycle. Upstream guarantees 1-cycle pulses.

Decomposition:
- Shared package seq_pkg: state enum (IDLE/ARMED/PLAYING), default NUM_STEPS/NUM_TRACKS, GATE_CYCLES_50MS constant, clog2 helper.
- Sub-module step_gate_timer: loadable down-counter plus gate mask register, with ports load, mask_in, clear, gate_out.
- FSM, index counter and pattern register file stay in the top module.

Test Plan:
- GATE_CYCLES=4, pattern track0={0,4,8,12}; Play, then Step every 10 cycles -> Trig[0] pulses at steps 0,4,8,12. Gate[0] high 4 cycles from each Trig. StepIndex wraps 15->0 and Trig[0] repeats.
- Play, no Step -> Playing=1, StepIndex=0, no Trig. First Step -> Trig on step-0 column 1 cycle later.
- GATE_CYCLES=20, Step every 10 cycles, track1 set on steps 0 and 1 -> Gate[1] stays high continuously across the boundary; two Trig[1] pulses.
- EditToggle on cell [2][3] in the same cycle that Step makes StepIndex=3 (cell was 0) -> no Trig[2]; EditValue=1 next cycle; Trig[2] fires on step 3 of the next loop.
- Stop and Play asserted in the same cycle while PLAYING with Gate high -> IDLE; Gate, Trig and StepIndex are 0 the next cycle.
- Clear plus EditToggle together, then nReset low for 1 cycle mid-play -> pattern all 0; all outputs 0; state IDLE.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the step sequencer and its gate timer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PLAYING = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_STEPS    = 16;
  localparam int DEF_NUM_TRACKS   = 4;
  localparam int GATE_CYCLES_50MS = 2_500_000;

  // Ceiling log2 that never returns less than 1, so single-entry selects still get a bit.
  function automatic int clog2_min1(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/step_gate_timer.sv
// Loadable gate down-counter with a per-track mask; gate_out is the mask while the count is nonzero.
module step_gate_timer
  import seq_pkg::*;
#(
  parameter int NUM_TRACKS  = DEF_NUM_TRACKS,
  parameter int GATE_CYCLES = GATE_CYCLES_50MS
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  load,
  input  logic [NUM_TRACKS-1:0] mask_in,
  input  logic                  clear,
  output logic [NUM_TRACKS-1:0] gate_out
);

  localparam int CNT_W = clog2_min1(GATE_CYCLES + 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_TRACKS-1:0] mask_q, mask_d;

  // A reload replaces the mask, so a track set in consecutive steps never drops.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (clear) begin
      cnt_d  = '0;
      mask_d = '0;
    end else if (load) begin
      cnt_d  = CNT_W'(GATE_CYCLES);
      mask_d = mask_in;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  assign gate_out = (cnt_q != '0) ? mask_q : '0;

endmodule

// File: rtl/step_sequencer.sv
// Looping step sequencer: play/stop FSM, step index, editable on/off pattern, per-track trig and gate.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int  NUM_STEPS   = DEF_NUM_STEPS,
  parameter int  NUM_TRACKS  = DEF_NUM_TRACKS,
  parameter int  GATE_CYCLES = GATE_CYCLES_50MS,
  localparam int STEP_W      = clog2_min1(NUM_STEPS),
  localparam int TRK_W       = clog2_min1(NUM_TRACKS)
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Step,
  input  logic                  Play,
  input  logic                  Stop,
  input  logic                  EditToggle,
  input  logic [TRK_W-1:0]      EditTrack,
  input  logic [STEP_W-1:0]     EditStep,
  input  logic                  Clear,
  output logic [STEP_W-1:0]     StepIndex,
  output logic [NUM_TRACKS-1:0] Trig,
  output logic [NUM_TRACKS-1:0] Gate,
  output logic                  Playing,
  output logic                  EditValue
);

  seq_state_e state_q, state_d;

  logic [STEP_W-1:0]     step_q, step_d;
  logic [STEP_W-1:0]     step_inc;
  logic [STEP_W-1:0]     sound_idx;
  logic                  sound;
  logic                  gate_clear;
  logic [NUM_TRACKS-1:0] trig_q, trig_d;
  logic [NUM_TRACKS-1:0] column;
  logic                  edit_value_q, edit_value_d;

  logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pattern_q, pattern_d;

  assign step_inc = step_q + STEP_W'(1);

  // Column read comes from the registered pattern, so a same-cycle edit lands on the next loop.
  generate
    for (genvar gi = 0; gi < NUM_TRACKS; gi++) begin : g_column
      assign column[gi] = pattern_q[gi][sound_idx];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    sound      = 1'b0;
    sound_idx  = step_q;
    gate_clear = 1'b0;
    if (Stop) begin
      state_d    = IDLE;
      step_d     = '0;
      gate_clear = 1'b1;
    end else if (Play) begin
      state_d    = ARMED;
      step_d     = '0;
      gate_clear = 1'b1;
    end else if (Step) begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        // The first tick after arming sounds step 0 without advancing.
        ARMED: begin
          state_d   = PLAYING;
          sound     = 1'b1;
          sound_idx = step_q;
        end
        PLAYING: begin
          step_d    = step_inc;
          sound     = 1'b1;
          sound_idx = step_inc;
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  assign trig_d = sound ? column : '0;

  always_comb begin
    pattern_d = pattern_q;
    if (Clear) begin
      pattern_d = '0;
    end else if (EditToggle) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        if (EditTrack == TRK_W'(t)) pattern_d[t][EditStep] = ~pattern_q[t][EditStep];
      end
    end
  end

  // Cursor readback uses the next-state pattern so an edit shows one cycle later.
  always_comb begin
    edit_value_d = 1'b0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      if (EditTrack == TRK_W'(t)) edit_value_d = pattern_d[t][EditStep];
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      trig_q       <= '0;
      pattern_q    <= '0;
      edit_value_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      trig_q       <= trig_d;
      pattern_q    <= pattern_d;
      edit_value_q <= edit_value_d;
    end
  end

  step_gate_timer #(
    .NUM_TRACKS (NUM_TRACKS),
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .Clock   (Clock),
    .nReset  (nReset),
    .load    (sound),
    .mask_in (column),
    .clear   (gate_clear),
    .gate_out(Gate)
  );

  assign StepIndex = step_q;
  assign Trig      = trig_q;
  assign Playing   = (state_q != IDLE);
  assign EditValue = edit_value_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios plus a randomized run against a cycle model.
module tb_step_sequencer;

  localparam int NS = 16;
  localparam int NT = 4;
  localparam int G  = 4;
  localparam int SW = 4;
  localparam int TW = 2;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          Step = 1'b0;
  logic          Play = 1'b0;
  logic          Stop = 1'b0;
  logic          EditToggle = 1'b0;
  logic [TW-1:0] EditTrack = '0;
  logic [SW-1:0] EditStep = '0;
  logic          Clear = 1'b0;
  logic [SW-1:0] StepIndex;
  logic [NT-1:0] Trig;
  logic [NT-1:0] Gate;
  logic          Playing;
  logic          EditValue;

  int checks = 0;
  int errors = 0;

  // Reference model: pattern as a plain bit matrix, gate as age since the last sounded step.
  bit            pat [NT][NS];
  int            m_mode;     // 0 idle, 1 armed, 2 playing
  int            m_idx;
  int            m_age;
  bit            m_gv;
  logic [NT-1:0] m_col;
  logic [NT-1:0] exp_trig;
  logic [NT-1:0] exp_gate;
  logic          exp_ev;
  logic          exp_playing;
  int            cur_trk = 0;
  int            cur_stp = 0;

  step_sequencer #(
    .NUM_STEPS  (NS),
    .NUM_TRACKS (NT),
    .GATE_CYCLES(G)
  ) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .Step      (Step),
    .Play      (Play),
    .Stop      (Stop),
    .EditToggle(EditToggle),
    .EditTrack (EditTrack),
    .EditStep  (EditStep),
    .Clear     (Clear),
    .StepIndex (StepIndex),
    .Trig      (Trig),
    .Gate      (Gate),
    .Playing   (Playing),
    .EditValue (EditValue)
  );

  always #5 Clock = ~Clock;

  task automatic drive_cycle(input bit rst, input bit stp_p, input bit play_p,
                             input bit stop_p, input bit tog_p, input bit clr_p);
    bit sounded;
    sounded    = 1'b0;
    nReset     = !rst;
    Step       = stp_p;
    Play       = play_p;
    Stop       = stop_p;
    EditToggle = tog_p;
    Clear      = clr_p;
    EditTrack  = TW'(cur_trk);
    EditStep   = SW'(cur_stp);
    @(posedge Clock);
    exp_trig = '0;
    if (rst) begin
      m_mode = 0;
      m_idx  = 0;
      m_gv   = 1'b0;
      m_age  = 0;
      m_col  = '0;
      for (int t = 0; t < NT; t++)
        for (int s = 0; s < NS; s++) pat[t][s] = 1'b0;
      exp_ev = 1'b0;
    end else begin
      if (stop_p) begin
        m_mode = 0;
        m_idx  = 0;
        m_gv   = 1'b0;
      end else if (play_p) begin
        m_mode = 1;
        m_idx  = 0;
        m_gv   = 1'b0;
      end else if (stp_p && m_mode != 0) begin
        if (m_mode == 2) m_idx = (m_idx + 1) % NS;
        m_mode = 2;
        for (int t = 0; t < NT; t++) m_col[t] = pat[t][m_idx];
        exp_trig = m_col;
        m_age    = 0;
        m_gv     = 1'b1;
        sounded  = 1'b1;
      end
      if (!sounded && m_age < 1000) m_age++;
      if (clr_p) begin
        for (int t = 0; t < NT; t++)
          for (int s = 0; s < NS; s++) pat[t][s] = 1'b0;
      end else if (tog_p) begin
        pat[cur_trk][cur_stp] = ~pat[cur_trk][cur_stp];
      end
      exp_ev = pat[cur_trk][cur_stp];
    end
    exp_gate    = (m_gv && m_age < G) ? m_col : '0;
    exp_playing = (m_mode != 0);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0);
    checks++;
    if (StepIndex !== '0) begin errors++; $display("FAIL reset_step_index: got %0d expected 0", StepIndex); end
    checks++;
    if (Trig !== '0) begin errors++; $display("FAIL reset_trig: got %b expected 0000", Trig); end
    checks++;
    if (Gate !== '0) begin errors++; $display("FAIL reset_gate: got %b expected 0000", Gate); end
    checks++;
    if (Playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b expected 0", Playing); end
    checks++;
    if (EditValue !== 1'b0) begin errors++; $display("FAIL reset_edit_value: got %b expected 0", EditValue); end
    drive_cycle(0, 0, 0, 0, 0, 0);
    $display("test_reset done");
  endtask

  task automatic test_pattern_loop();
    int gcnt;
    drive_cycle(0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cur_trk = 0;
      cur_stp = k * 4;
      drive_cycle(0, 0, 0, 0, 1, 0);
    end
    drive_cycle(0, 0, 1, 0, 0, 0);
    for (int n = 0; n < 17; n++) begin
      drive_cycle(0, 1, 0, 0, 0, 0);
      $display("loop step %0d: StepIndex=%0d Trig=%b Gate=%b", n, StepIndex, Trig, Gate);
      checks++;
      if (StepIndex !== SW'(n % 16)) begin
        errors++; $display("FAIL loop_step_index: got %0d expected %0d", StepIndex, n % 16);
      end
      checks++;
      if (Trig[0] !== (n % 4 == 0)) begin
        errors++; $display("FAIL loop_trig0 step %0d: got %b expected %b", n, Trig[0], (n % 4 == 0));
      end
      gcnt = 0;
      if (Gate[0]) gcnt++;
      for (int k = 0; k < 9; k++) begin
        drive_cycle(0, 0, 0, 0, 0, 0);
        if (Gate[0]) gcnt++;
      end
      checks++;
      if (gcnt != ((n % 4 == 0) ? 4 : 0)) begin
        errors++; $display("FAIL loop_gate0_len step %0d: got %0d expected %0d", n, gcnt, (n % 4 == 0) ? 4 : 0);
      end
    end
  endtask

  task automatic test_armed_no_step();
    bit trig_seen;
    drive_cycle(0, 0, 0, 1, 0, 1);
    cur_trk = 1; cur_stp = 0; drive_cycle(0, 0, 0, 0, 1, 0);
    cur_trk = 3; cur_stp = 0; drive_cycle(0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 1, 0, 0, 0);
    trig_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      if (Trig != '0) trig_seen = 1'b1;
    end
    checks++;
    if (Playing !== 1'b1) begin errors++; $display("FAIL armed_playing: got %b expected 1", Playing); end
    checks++;
    if (StepIndex !== '0) begin errors++; $display("FAIL armed_step_index: got %0d expected 0", StepIndex); end
    checks++;
    if (trig_seen !== 1'b0) begin errors++; $display("FAIL armed_no_trig: got %b expected 0", trig_seen); end
    drive_cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (Trig !== 4'b1010) begin errors++; $display("FAIL armed_first_trig: got %b expected 1010", Trig); end
    checks++;
    if (Gate !== 4'b1010) begin errors++; $display("FAIL armed_first_gate: got %b expected 1010", Gate); end
    checks++;
    if (StepIndex !== '0) begin errors++; $display("FAIL armed_first_index: got %0d expected 0", StepIndex); end
    $display("test_armed_no_step done");
  endtask

  task automatic test_back_to_back();
    logic [8:0] gseq;
    logic [8:0] tseq;
    drive_cycle(0, 0, 0, 1, 0, 1);
    cur_trk = 1; cur_stp = 0; drive_cycle(0, 0, 0, 0, 1, 0);
    cur_trk = 1; cur_stp = 1; drive_cycle(0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive_cycle(0, (i == 0 || i == 3), 0, 0, 0, 0);
      gseq[i] = Gate[1];
      tseq[i] = Trig[1];
    end
    checks++;
    if (gseq !== 9'b001111111) begin errors++; $display("FAIL b2b_gate1_seq: got %b expected 001111111", gseq); end
    checks++;
    if (tseq !== 9'b000001001) begin errors++; $display("FAIL b2b_trig1_seq: got %b expected 000001001", tseq); end
    $display("test_back_to_back done");
  endtask

  task automatic test_edit_same_cycle();
    int early;
    drive_cycle(0, 0, 0, 1, 0, 1);
    drive_cycle(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive_cycle(0, 1, 0, 0, 0, 0);
    cur_trk = 2; cur_stp = 3;
    drive_cycle(0, 1, 0, 0, 1, 0);
    checks++;
    if (StepIndex !== 4'd3) begin errors++; $display("FAIL edit_step_index: got %0d expected 3", StepIndex); end
    checks++;
    if (Trig[2] !== 1'b0) begin errors++; $display("FAIL edit_same_cycle_trig2: got %b expected 0", Trig[2]); end
    checks++;
    if (EditValue !== 1'b1) begin errors++; $display("FAIL edit_value_after_toggle: got %b expected 1", EditValue); end
    early = 0;
    for (int k = 0; k < 15; k++) begin
      drive_cycle(0, 1, 0, 0, 0, 0);
      if (Trig[2]) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL edit_spurious_trig2: got %0d expected 0", early); end
    drive_cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (Trig[2] !== 1'b1) begin errors++; $display("FAIL edit_next_loop_trig2: got %b expected 1", Trig[2]); end
    $display("test_edit_same_cycle done");
  endtask

  task automatic test_stop_play();
    checks++;
    if (Gate[2] !== 1'b1) begin errors++; $display("FAIL stop_pre_gate2: got %b expected 1", Gate[2]); end
    drive_cycle(0, 0, 1, 1, 0, 0);
    checks++;
    if (Playing !== 1'b0) begin errors++; $display("FAIL stop_playing: got %b expected 0", Playing); end
    checks++;
    if (Gate !== '0) begin errors++; $display("FAIL stop_gate: got %b expected 0000", Gate); end
    checks++;
    if (Trig !== '0) begin errors++; $display("FAIL stop_trig: got %b expected 0000", Trig); end
    checks++;
    if (StepIndex !== '0) begin errors++; $display("FAIL stop_step_index: got %0d expected 0", StepIndex); end
    cur_trk = 2; cur_stp = 0;
    drive_cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (Trig !== '0 || Playing !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_step: got trig %b playing %b expected 0000 0", Trig, Playing);
    end
    $display("test_stop_play done");
  endtask

  task automatic test_clear_reset();
    drive_cycle(0, 0, 1, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0);
    cur_trk = 0; cur_stp = 5;
    drive_cycle(0, 0, 0, 0, 1, 1);
    checks++;
    if (EditValue !== 1'b0) begin errors++; $display("FAIL clear_beats_toggle: got %b expected 0", EditValue); end
    cur_trk = 2; cur_stp = 3;
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (EditValue !== 1'b0) begin errors++; $display("FAIL clear_zeroes_cell: got %b expected 0", EditValue); end
    cur_trk = 1; cur_stp = 0;
    drive_cycle(0, 0, 0, 0, 1, 0);
    checks++;
    if (EditValue !== 1'b1) begin errors++; $display("FAIL toggle_before_reset: got %b expected 1", EditValue); end
    drive_cycle(0, 1, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0);
    checks++;
    if ({StepIndex, Trig, Gate, Playing, EditValue} !== '0) begin
      errors++; $display("FAIL midplay_reset_outputs: got idx %0d trig %b gate %b play %b ev %b expected all 0",
                          StepIndex, Trig, Gate, Playing, EditValue);
    end
    drive_cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (EditValue !== 1'b0) begin errors++; $display("FAIL reset_clears_pattern: got %b expected 0", EditValue); end
    drive_cycle(0, 0, 1, 0, 0, 0);
    drive_cycle(0, 1, 0, 0, 0, 0);
    checks++;
    if (Trig !== '0) begin errors++; $display("FAIL reset_pattern_trig: got %b expected 0000", Trig); end
    $display("test_clear_reset done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      cur_trk = $urandom_range(0, NT - 1);
      cur_stp = $urandom_range(0, NS - 1);
      drive_cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
      checks++;
      if (StepIndex !== SW'(m_idx)) begin errors++; $display("FAIL rand_step_index cyc %0d: got %0d expected %0d", n, StepIndex, m_idx); end
      checks++;
      if (Trig !== exp_trig) begin errors++; $display("FAIL rand_trig cyc %0d: got %b expected %b", n, Trig, exp_trig); end
      checks++;
      if (Gate !== exp_gate) begin errors++; $display("FAIL rand_gate cyc %0d: got %b expected %b", n, Gate, exp_gate); end
      checks++;
      if (Playing !== exp_playing) begin errors++; $display("FAIL rand_playing cyc %0d: got %b expected %b", n, Playing, exp_playing); end
      checks++;
      if (EditValue !== exp_ev) begin errors++; $display("FAIL rand_edit_value cyc %0d: got %b expected %b", n, EditValue, exp_ev); end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_pattern_loop();
    test_armed_no_step();
    test_back_to_back();
    test_edit_same_cycle();
    test_stop_play();
    test_clear_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
